// File: rtl/banked_shared_mem_pkg.sv
// Shared configuration, types and address-mapping helpers for the banked
// shared memory. Blocks are word-interleaved: low address bits pick the bank,
// the remaining bits pick the row inside that bank.
package shared_mem_pkg;

  localparam int PORT_COUNT = 4;
  localparam int BANK_COUNT = 4;
  localparam int BUS_SIZE   = 160;
  localparam int UNIT_SIZE  = 32;
  localparam int MEM_SIZE   = 1024;
  localparam int ADDR_SIZE  = 24;

  localparam int BLOCK     = BUS_SIZE / UNIT_SIZE;
  localparam int ROWS      = MEM_SIZE / BANK_COUNT;
  localparam int BANK_BITS = $clog2(BANK_COUNT);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PIDX_W    = $clog2(PORT_COUNT);

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [BUS_SIZE-1:0]  block_t;
  typedef logic [2:0]           wr_size_t;
  typedef logic [BANK_W-1:0]    bank_t;

  function automatic bank_t bank_of(addr_t a);
    return bank_t'(a & addr_t'(BANK_COUNT - 1));
  endfunction

  function automatic addr_t row_of(addr_t a);
    return a >> BANK_BITS;
  endfunction

endpackage

// File: rtl/banked_shared_mem_if.sv
// Per-port request/grant and read-response bundle of the banked shared memory.
// master = processor LSU side, slave = memory side.
interface banked_shared_mem_if
  import shared_mem_pkg::*;
();

  logic [PORT_COUNT-1:0] req;
  logic [PORT_COUNT-1:0] we;
  addr_t                 addr    [PORT_COUNT];
  block_t                wdata   [PORT_COUNT];
  wr_size_t              wr_size [PORT_COUNT];
  logic [PORT_COUNT-1:0] gnt;
  logic [PORT_COUNT-1:0] rvalid;
  block_t                rdata   [PORT_COUNT];

  modport master (
    output req, we, addr, wdata, wr_size,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wr_size,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/banked_shared_mem_arbiter.sv
// Round-robin arbiter for one bank. The search starts at the pointer; after a
// grant to port k the pointer moves to k+1, with no grant it holds. Grants are
// suppressed while reset is high.
module bank_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] ptr;

  // Pick the first requester at or after the pointer
  always_comb begin
    int  k;
    logic found;
    k     = 0;
    found = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && !i_rst && i_req[k]) begin
        found    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDX_W'(k);
      end
    end
  end

  // Advance the pointer past the winner
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (|o_gnt) begin
      ptr <= (o_idx == IDX_W'(N_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/banked_shared_mem.sv
// Banked shared scratchpad: PORT_COUNT ports, BANK_COUNT word-interleaved
// banks, one round-robin arbiter per bank, unit-granular writes and a
// one-cycle registered read response.
// Optional build macro BANKED_MEM_STATS_EN adds o_stall_cnt, a per-port
// saturating count of cycles spent requesting without a grant.
module banked_shared_mem
  import shared_mem_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  banked_shared_mem_if.slave bus
`ifdef BANKED_MEM_STATS_EN
  ,
  output logic [15:0] o_stall_cnt [PORT_COUNT]
`endif
);

  logic [UNIT_SIZE-1:0]  mem      [BANK_COUNT][ROWS][BLOCK];
  logic [PORT_COUNT-1:0] bank_req [BANK_COUNT];
  logic [PORT_COUNT-1:0] bank_gnt [BANK_COUNT];
  logic [PIDX_W-1:0]     bank_idx [BANK_COUNT];
  logic [PORT_COUNT-1:0] gnt_all;
  logic [PORT_COUNT-1:0] port_ok;
  logic [ROW_W-1:0]      port_row [PORT_COUNT];
  block_t                port_rd  [PORT_COUNT];
  logic [BLOCK-1:0]      unit_we  [BANK_COUNT];
  logic [ROW_W-1:0]      wr_row   [BANK_COUNT];
  block_t                wr_data  [BANK_COUNT];
  logic [PORT_COUNT-1:0] rvalid_q;
  block_t                rdata_q  [PORT_COUNT];

  // Per-port decode: row, range check, and the block currently addressed
  always_comb begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      port_ok[p]  = row_of(bus.addr[p]) < addr_t'(ROWS);
      port_row[p] = ROW_W'(row_of(bus.addr[p]));
      port_rd[p]  = '0;
      for (int u = 0; u < BLOCK; u++) begin
        port_rd[p][u*UNIT_SIZE +: UNIT_SIZE] = mem[bank_of(bus.addr[p])][port_row[p]][u];
      end
      if (!port_ok[p]) port_rd[p] = '0;
    end
  end

  // Steer each request to the arbiter of the bank it addresses
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        bank_req[b][p] = bus.req[p] && (bank_of(bus.addr[p]) == bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    bank_rr_arbiter #(.N_REQ(PORT_COUNT)) u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req (bank_req[b]),
      .o_gnt (bank_gnt[b]),
      .o_idx (bank_idx[b])
    );
  end

  // A port sits in exactly one bank, so OR-ing the bank grants is safe
  always_comb begin
    gnt_all = '0;
    for (int b = 0; b < BANK_COUNT; b++) gnt_all |= bank_gnt[b];
  end

  assign bus.gnt = gnt_all;

  // Per-bank write port: winner's row/data, unit enables from the write size
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      unit_we[b] = '0;
      wr_row[b]  = port_row[bank_idx[b]];
      wr_data[b] = bus.wdata[bank_idx[b]];
      if (|bank_gnt[b] && bus.we[bank_idx[b]] && port_ok[bank_idx[b]]) begin
        for (int u = 0; u < BLOCK; u++) begin
          unit_we[b][u] = 32'(bus.wr_size[bank_idx[b]]) > u;
        end
      end
    end
  end

  // Bank storage with per-unit enables; contents survive reset
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int u = 0; u < BLOCK; u++) begin
        if (unit_we[b][u]) mem[b][wr_row[b]][u] <= wr_data[b][u*UNIT_SIZE +: UNIT_SIZE];
      end
    end
  end

  // Read response one cycle after a read grant; data holds between responses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_q <= '0;
      for (int p = 0; p < PORT_COUNT; p++) rdata_q[p] <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        rvalid_q[p] <= gnt_all[p] && !bus.we[p];
        if (gnt_all[p] && !bus.we[p]) rdata_q[p] <= port_rd[p];
      end
    end
  end

  // A response still in flight when reset arrives is dropped
  assign bus.rvalid = rvalid_q & ~{PORT_COUNT{i_rst}};
  assign bus.rdata  = rdata_q;

`ifdef BANKED_MEM_STATS_EN
  logic [15:0] stall_q [PORT_COUNT];

  // Saturating count of cycles each port waits for its bank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int p = 0; p < PORT_COUNT; p++) stall_q[p] <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (bus.req[p] && !gnt_all[p] && stall_q[p] != 16'hFFFF) stall_q[p] <= stall_q[p] + 16'd1;
      end
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_banked_shared_mem.sv
// Scoreboard bench for banked_shared_mem: a flat block-addressed memory model
// and a per-bank round-robin model predict grants and read data.
module tb_banked_shared_mem;
  import shared_mem_pkg::*;

  logic   clk;
  logic   rst;
  int     cyc;
  int     n_cmp;
  int     n_err;
  block_t model  [MEM_SIZE];
  block_t exp_q  [PORT_COUNT][$];
  int     rr_ptr [BANK_COUNT];
  int     gc     [PORT_COUNT];

  banked_shared_mem_if bus();

`ifdef BANKED_MEM_STATS_EN
  logic [15:0] stall_cnt [PORT_COUNT];
`endif

  banked_shared_mem dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef BANKED_MEM_STATS_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input block_t act, input block_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic block_t rnd_block();
    block_t b;
    for (int u = 0; u < BLOCK; u++) b[u*UNIT_SIZE +: UNIT_SIZE] = $urandom;
    return b;
  endfunction

  // Observe one cycle: response checks, arbitration checks, model update
  task automatic monitor_step();
    int w;
    int a;
    logic [PORT_COUNT-1:0] exp_m;
    logic [PORT_COUNT-1:0] act_m;
    if (rst) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        chki("gnt_in_reset", int'(bus.gnt[p]), 0);
        chki("rvalid_in_reset", int'(bus.rvalid[p]), 0);
        exp_q[p].delete();
      end
      for (int b = 0; b < BANK_COUNT; b++) rr_ptr[b] = 0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (bus.rvalid[p]) begin
          if (exp_q[p].size() == 0) chki("rvalid_unexpected", int'(bus.rvalid[p]), 0);
          else chk($sformatf("rdata_p%0d", p), bus.rdata[p], exp_q[p].pop_front());
        end else if (exp_q[p].size() != 0) begin
          chki("rvalid_missing", int'(bus.rvalid[p]), 1);
          void'(exp_q[p].pop_front());
        end
      end
      for (int b = 0; b < BANK_COUNT; b++) begin
        w = -1;
        exp_m = '0;
        act_m = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
          a = (rr_ptr[b] + i) % PORT_COUNT;
          if (w < 0 && bus.req[a] && (int'(bus.addr[a]) % BANK_COUNT) == b) w = a;
        end
        for (int p = 0; p < PORT_COUNT; p++)
          if ((int'(bus.addr[p]) % BANK_COUNT) == b) act_m[p] = bus.gnt[p];
        if (w >= 0) begin
          exp_m[w] = 1'b1;
          rr_ptr[b] = (w + 1) % PORT_COUNT;
        end
        chki($sformatf("arb_bank%0d", b), int'(act_m), int'(exp_m));
      end
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (bus.gnt[p]) begin
          a = int'(bus.addr[p]);
          if (bus.we[p]) begin
            if (a < MEM_SIZE)
              for (int u = 0; u < BLOCK; u++)
                if (u < int'(bus.wr_size[p]))
                  model[a][u*UNIT_SIZE +: UNIT_SIZE] = bus.wdata[p][u*UNIT_SIZE +: UNIT_SIZE];
          end else begin
            exp_q[p].push_back((a < MEM_SIZE) ? model[a] : '0);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one access on port p and hold it until granted (bounded)
  task automatic do_req(input int p, input logic we, input int addr, input block_t d,
                        input int size, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    bus.req[p]     = 1'b1;
    bus.we[p]      = we;
    bus.addr[p]    = addr_t'(addr);
    bus.wdata[p]   = d;
    bus.wr_size[p] = wr_size_t'(size);
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.gnt[p]) begin
        got = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) chki($sformatf("gnt_timeout_p%0d", p), int'(bus.gnt[p]), 1);
    @(posedge clk);
    #1;
    bus.req[p] = 1'b0;
  endtask

  task automatic par_read(input int base, input int stride);
    for (int p = 0; p < PORT_COUNT; p++) begin
      fork
        automatic int pp = p;
        do_req(pp, 1'b0, base + pp * stride, '0, 0, gc[pp]);
      join_none
    end
    wait fork;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic rand_port(input int p);
    int g;
    int a;
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? MEM_SIZE + $urandom_range(0, 7) : $urandom_range(0, 31);
      do_req(p, 1'($urandom_range(0, 1)), a, rnd_block(), $urandom_range(0, 7), g);
    end
  endtask

  task automatic run_tests();
    int s;
    int g;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < PORT_COUNT; p++) begin
      chki("post_reset_rvalid", int'(bus.rvalid[p]), 0);
      chk("post_reset_rdata", bus.rdata[p], '0);
    end
    idle(1);

    for (int a = 0; a < 32; a++) do_req(0, 1'b1, a, rnd_block(), 5, g);

    // write then read two cycles later
    do_req(0, 1'b1, 5, {BLOCK{32'hAAAAAAAA}}, 5, g);
    idle(1);
    s = cyc;
    do_req(1, 1'b0, 5, '0, 0, g);
    chki("t1_gnt_latency", g - s, 0);
    @(negedge clk);
    chki("t1_rvalid", int'(bus.rvalid[1]), 1);
    chk("t1_rdata", bus.rdata[1], {BLOCK{32'hAAAAAAAA}});
    idle(1);

    // distinct banks in parallel
    s = cyc;
    par_read(0, 1);
    for (int p = 0; p < PORT_COUNT; p++) chki($sformatf("t2_parallel_p%0d", p), gc[p] - s, 0);

    // all on bank 0: round-robin order from port 0, twice
    pulse_reset(2);
    s = cyc;
    par_read(0, BANK_COUNT);
    for (int p = 0; p < PORT_COUNT; p++) chki($sformatf("t3_order_p%0d", p), gc[p] - s, p);
`ifdef BANKED_MEM_STATS_EN
    @(negedge clk);
    for (int p = 0; p < PORT_COUNT; p++) chki($sformatf("stall_p%0d", p), int'(stall_cnt[p]), p);
    idle(1);
`endif
    s = cyc;
    par_read(0, BANK_COUNT);
    for (int p = 0; p < PORT_COUNT; p++) chki($sformatf("t3_repeat_p%0d", p), gc[p] - s, p);

    // partial write over a full one
    do_req(0, 1'b1, 9, '1, 5, g);
    do_req(0, 1'b1, 9, '0, 2, g);
    do_req(0, 1'b0, 9, '0, 0, g);
    @(negedge clk);
    chk("t4_partial", bus.rdata[0], {{3{32'hFFFFFFFF}}, 64'h0});
    idle(1);

    // out-of-range read and write
    do_req(0, 1'b0, MEM_SIZE + 3, '0, 0, g);
    @(negedge clk);
    chki("t5_oor_rvalid", int'(bus.rvalid[0]), 1);
    chk("t5_oor_rdata", bus.rdata[0], '0);
    idle(1);
    do_req(0, 1'b1, MEM_SIZE + 3, rnd_block(), 5, g);
    do_req(1, 1'b0, 3, '0, 0, g);
    @(negedge clk);
    chk("t5_row_kept", bus.rdata[1], model[3]);
    idle(1);

    // reset right after a read grant drops the response
    do_req(2, 1'b0, 6, '0, 0, g);
    rst = 1'b1;
    @(negedge clk);
    chki("t6_rvalid_dropped", int'(bus.rvalid[2]), 0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chki("t6_no_rvalid_after", int'(bus.rvalid[2]), 0);
    end
`ifdef BANKED_MEM_STATS_EN
    for (int p = 0; p < PORT_COUNT; p++) chki("stall_cleared", int'(stall_cnt[p]), 0);
`endif
    idle(1);

    for (int p = 0; p < PORT_COUNT; p++) begin
      fork
        automatic int pp = p;
        rand_port(pp);
      join_none
    end
    wait fork;
    idle(3);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.we  = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      bus.addr[p]    = '0;
      bus.wdata[p]   = '0;
      bus.wr_size[p] = '0;
    end
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin
        run_tests();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join
  end

endmodule
